// File: rtl/rsa_uart_responder_if.sv
// Avalon-MM slave bus bundle for the RS232 UART register model.
// The master modport is the wrapper side and the slave modport is the responder side.
interface rsa_uart_responder_if;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/rsa_uart_responder.sv
// Avalon-MM model of the RS232 UART register map.
// An RX FIFO is fed by host bytes, and a TX FIFO is drained by a byte stream.
module rsa_uart_responder #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                       avm_clk,
    input  logic                       avm_rst,
    rsa_uart_responder_if.slave        avs,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [2:0] W_RX     = 3'd0;
    localparam logic [2:0] W_TX     = 3'd1;
    localparam logic [2:0] W_STATUS = 3'd2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

    state_e          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            waitreq_q, waitreq_d;
    logic            pop_rx_q, pop_rx_d;
    logic            set_rue_q, set_rue_d;
    logic            push_tx_q, push_tx_d;
    logic            clr_q, clr_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            toe_q, toe_d;
    logic            rue_q, rue_d;

    logic [7:0]      rx_mem_q [FIFO_DEPTH];
    logic [7:0]      rx_mem_d [FIFO_DEPTH];
    logic [PW-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]      tx_mem_q [FIFO_DEPTH];
    logic [7:0]      tx_mem_d [FIFO_DEPTH];
    logic [PW-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;

    logic            rx_full, tx_full, rx_empty;
    logic            rx_push, rx_pop, tx_push, tx_pop;
    logic            req, start_ack;
    logic [2:0]      word;
    logic [31:0]     status;
    logic            unused_bits;

    assign unused_bits = ^{avs.avs_writedata[31:8], avs.avs_address[1:0]};

    assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
    assign rx_ready = !rx_full;
    assign tx_valid = (tx_cnt_q != '0);
    assign tx_data  = tx_mem_q[tx_rd_q];
    assign word     = avs.avs_address[4:2];
    assign req      = avs.avs_read | avs.avs_write;

    assign avs.avs_readdata    = readdata_q;
    assign avs.avs_waitrequest = waitreq_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        readdata_d = readdata_q;
        pop_rx_d   = pop_rx_q;
        set_rue_d  = set_rue_q;
        push_tx_d  = push_tx_q;
        clr_d      = clr_q;
        tx_byte_d  = tx_byte_q;
        toe_d      = toe_q;
        rue_d      = rue_q;
        rx_mem_d   = rx_mem_q;
        rx_wr_d    = rx_wr_q;
        rx_rd_d    = rx_rd_q;
        rx_cnt_d   = rx_cnt_q;
        tx_mem_d   = tx_mem_q;
        tx_wr_d    = tx_wr_q;
        tx_rd_d    = tx_rd_q;
        tx_cnt_d   = tx_cnt_q;
        start_ack  = 1'b0;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        status     = {24'b0, !rx_empty, !tx_full, 2'b00, toe_q, rue_q, 2'b00};

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        start_ack = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q <= 4'd1) begin
                    start_ack = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                // Actions were decided on entry; they commit here so that the
                // readdata snapshot and the side effect always agree.
                rx_pop  = pop_rx_q;
                tx_push = push_tx_q && !tx_full;
                if (push_tx_q && tx_full) toe_d = 1'b1;
                if (set_rue_q) rue_d = 1'b1;
                if (clr_q) begin
                    toe_d = 1'b0;
                    rue_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_ack) begin
            state_d    = S_ACK;
            readdata_d = '0;
            pop_rx_d   = 1'b0;
            set_rue_d  = 1'b0;
            push_tx_d  = 1'b0;
            clr_d      = 1'b0;
            tx_byte_d  = avs.avs_writedata[7:0];
            if (avs.avs_read) begin
                case (word)
                    W_RX: begin
                        if (!rx_empty) begin
                            readdata_d = {24'b0, rx_mem_q[rx_rd_q]};
                            pop_rx_d   = 1'b1;
                        end else begin
                            set_rue_d  = 1'b1;
                        end
                    end
                    W_STATUS: readdata_d = status;
                    default:  readdata_d = '0;
                endcase
            end else begin
                case (word)
                    W_TX:     push_tx_d = 1'b1;
                    W_STATUS: clr_d     = 1'b1;
                    default:  ;
                endcase
            end
        end

        waitreq_d = (state_d != S_ACK);

        // Push uses the registered count, so a full FIFO never accepts in a pop cycle.
        rx_push = rx_valid && !rx_full;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_data;
            rx_wr_d           = rx_wr_q + PW'(1);
        end
        if (rx_pop) rx_rd_d = rx_rd_q + PW'(1);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);

        tx_pop = tx_valid && tx_ready;
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = tx_byte_q;
            tx_wr_d           = tx_wr_q + PW'(1);
        end
        if (tx_pop) tx_rd_d = tx_rd_q + PW'(1);
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    end

    always_ff @(posedge avm_clk) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
        if (avm_rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            readdata_q <= '0;
            waitreq_q  <= 1'b1;
            pop_rx_q   <= 1'b0;
            set_rue_q  <= 1'b0;
            push_tx_q  <= 1'b0;
            clr_q      <= 1'b0;
            tx_byte_q  <= '0;
            toe_q      <= 1'b0;
            rue_q      <= 1'b0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            readdata_q <= readdata_d;
            waitreq_q  <= waitreq_d;
            pop_rx_q   <= pop_rx_d;
            set_rue_q  <= set_rue_d;
            push_tx_q  <= push_tx_d;
            clr_q      <= clr_d;
            tx_byte_q  <= tx_byte_d;
            toe_q      <= toe_d;
            rue_q      <= rue_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end
endmodule

// File: tb/tb_rsa_uart_responder.sv
// Scoreboard bench for rsa_uart_responder: one instance with one wait cycle and
// one with three wait cycles; read data and TX bytes are checked by monitors.
module tb_rsa_uart_responder;
    logic clk = 1'b0;
    logic rst, rst3;
    always #5 clk = ~clk;

    rsa_uart_responder_if b1();
    rsa_uart_responder_if b3();

    logic [7:0] rx_data1, rx_data3, tx_data1, tx_data3;
    logic       rx_valid1, rx_valid3, rx_ready1, rx_ready3;
    logic       tx_valid1, tx_valid3, tx_ready1, tx_ready3;

    rsa_uart_responder #(.FIFO_DEPTH(4), .WAIT_CYCLES(1)) dut1 (
        .avm_clk(clk), .avm_rst(rst), .avs(b1.slave),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1)
    );

    rsa_uart_responder #(.FIFO_DEPTH(4), .WAIT_CYCLES(3)) dut3 (
        .avm_clk(clk), .avm_rst(rst3), .avs(b3.slave),
        .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q1[$];
    logic [31:0] q3[$];
    logic [7:0]  txq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (b1.avs_read === 1'b1 && b1.avs_waitrequest === 1'b0) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd1_unexpected: got ack with %h expected no ack", b1.avs_readdata);
            end else chk("rd1_data", b1.avs_readdata, q1.pop_front());
        end
        if (b3.avs_read === 1'b1 && b3.avs_waitrequest === 1'b0) begin
            if (q3.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd3_unexpected: got ack with %h expected no ack", b3.avs_readdata);
            end else chk("rd3_data", b3.avs_readdata, q3.pop_front());
        end
        if (tx_valid1 === 1'b1 && tx_ready1 === 1'b1) begin
            if (txq.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL tx1_unexpected: got byte %h expected none", tx_data1);
            end else chk("tx1_data", {24'b0, tx_data1}, {24'b0, txq.pop_front()});
        end
    end

    // One Avalon access; read expectations go to the scoreboard, latency is checked here.
    task automatic bus(input bit sel, input bit is_wr, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        int unsigned cyc;
        bit acked;
        if (!is_wr) begin
            if (sel) q3.push_back(exp); else q1.push_back(exp);
        end
        @(posedge clk); #1;
        if (sel) begin
            b3.avs_address = addr; b3.avs_read = !is_wr; b3.avs_write = is_wr; b3.avs_writedata = wdata;
        end else begin
            b1.avs_address = addr; b1.avs_read = !is_wr; b1.avs_write = is_wr; b1.avs_writedata = wdata;
        end
        cyc = 0; acked = 1'b0;
        while (!acked && cyc < 40) begin
            @(negedge clk);
            cyc++;
            acked = sel ? (b3.avs_waitrequest === 1'b0) : (b1.avs_waitrequest === 1'b0);
        end
        chk(sel ? "latency3" : "latency1", cyc, sel ? 32'd5 : 32'd3);
        @(posedge clk); #1;
        if (sel) begin b3.avs_read = 1'b0; b3.avs_write = 1'b0; end
        else begin b1.avs_read = 1'b0; b1.avs_write = 1'b0; end
    endtask

    task automatic push1(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data1 = b; rx_valid1 = 1'b1;
        chk("rx1_ready", rx_ready1, 1);
        @(posedge clk); #1;
        rx_valid1 = 1'b0;
    endtask

    task automatic push3(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data3 = b; rx_valid3 = 1'b1;
        chk("rx3_ready", rx_ready3, 1);
        @(posedge clk); #1;
        rx_valid3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acks;
        bit acked;
        rst = 1'b1; rst3 = 1'b1;
        b1.avs_address = '0; b1.avs_read = 1'b0; b1.avs_write = 1'b0; b1.avs_writedata = '0;
        b3.avs_address = '0; b3.avs_read = 1'b0; b3.avs_write = 1'b0; b3.avs_writedata = '0;
        rx_data1 = '0; rx_valid1 = 1'b0; tx_ready1 = 1'b0;
        rx_data3 = '0; rx_valid3 = 1'b0; tx_ready3 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_waitreq", b1.avs_waitrequest, 1);
        chk("rst_readdata", b1.avs_readdata, 0);
        chk("rst_rx_ready", rx_ready1, 1);
        chk("rst_tx_valid", tx_valid1, 0);
        @(posedge clk); #1;
        rst = 1'b0; rst3 = 1'b0;

        bus(0, 0, 5'd8, 0, 32'h40);
        push1(8'hA5);
        push1(8'h3C);
        bus(0, 0, 5'd8, 0, 32'hC0);
        bus(0, 0, 5'd0, 0, 32'hA5);
        bus(0, 0, 5'd0, 0, 32'h3C);
        bus(0, 0, 5'd8, 0, 32'h40);

        bus(0, 0, 5'd0, 0, 32'h0);
        bus(0, 0, 5'd8, 0, 32'h44);
        bus(0, 1, 5'd8, 32'h0, 0);
        bus(0, 0, 5'd8, 0, 32'h40);
        bus(0, 0, 5'd4, 0, 32'h0);

        for (int i = 0; i < 5; i++) bus(0, 1, 5'd4, 32'h11 + i, 0);
        bus(0, 0, 5'd8, 0, 32'h08);
        for (int i = 0; i < 4; i++) txq.push_back(8'h11 + 8'(i));
        tx_ready1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (txq.size() == 0) break;
        end
        @(negedge clk);
        chk("tx1_drained", txq.size(), 0);
        chk("tx1_valid_empty", tx_valid1, 0);
        bus(0, 1, 5'd8, 32'hFF, 0);
        bus(0, 0, 5'd8, 0, 32'h40);

        @(posedge clk); #1;
        rx_valid1 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rx_data1 = 8'(i);
            @(posedge clk); #1;
        end
        rx_data1 = 8'h05;
        chk("rx1_full_ready", rx_ready1, 0);
        bus(0, 0, 5'd0, 0, 32'h01);
        chk("rx1_ready_after_pop", rx_ready1, 1);
        @(posedge clk); #1;
        rx_valid1 = 1'b0;
        chk("rx1_refull", rx_ready1, 0);
        for (int i = 2; i <= 5; i++) bus(0, 0, 5'd0, 0, i);
        bus(0, 0, 5'd8, 0, 32'h40);

        push3(8'h77);
        bus(1, 0, 5'd8, 0, 32'hC0);
        @(posedge clk); #1;
        b3.avs_address = 5'd0; b3.avs_read = 1'b1;
        @(posedge clk); #1;
        b3.avs_read = 1'b0;
        acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (b3.avs_waitrequest === 1'b0) acks++;
        end
        chk("drop_noack", acks, 0);
        bus(1, 0, 5'd8, 0, 32'hC0);
        bus(1, 0, 5'd0, 0, 32'h77);

        push3(8'h66);
        q3.push_back(32'h66);
        @(posedge clk); #1;
        b3.avs_address = 5'd0; b3.avs_read = 1'b1;
        acked = 1'b0;
        for (int i = 0; i < 20 && !acked; i++) begin
            @(negedge clk);
            acked = (b3.avs_waitrequest === 1'b0);
        end
        chk("rst3_reached_ack", acked, 1);
        rst3 = 1'b1;
        @(posedge clk); #1;
        b3.avs_read = 1'b0;
        @(negedge clk);
        chk("rst3_readdata", b3.avs_readdata, 0);
        chk("rst3_rx_ready", rx_ready3, 1);
        chk("rst3_waitreq", b3.avs_waitrequest, 1);
        @(posedge clk); #1;
        rst3 = 1'b0;
        bus(1, 0, 5'd8, 0, 32'h40);

        repeat (2) @(posedge clk);
        chk("q1_empty", q1.size(), 0);
        chk("q3_empty", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
